router_fsm_np: RTL and testbench

ROUTER_FSM_NP -- requirements
Module: router_fsm_np

---
 rtl/router_fsm_np.sv | 226 ++++++++++++++++++++++
 tb/tb_router_fsm_np.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_np.sv
// ---------------------------------------------------------------------------
// router_fsm_np
// Control FSM of a packet router. It decodes the header address, sequences
// the write of header/payload/parity into the selected output FIFO, stalls
// the source while the FIFO is full or still draining, drops packets with
// invalid addresses and, optionally, drops packets whose destination FIFO
// does not empty within WAIT_TIMEOUT cycles.
//
// Parameters
//   NUM_PORTS     number of output ports (2 .. 2**ADDR_W)
//   ADDR_W        header address width
//   WAIT_TIMEOUT  cycle limit in WAIT_TILL_EMPTY (0 disables the timeout)
//
// Ports
//   clock             rising-edge clock
//   resetn            synchronous active-low reset
//   pkt_valid         source packet valid
//   data_in           header address bits
//   fifo_full         full flag of the selected FIFO
//   fifo_empty        per-port FIFO empty flags
//   soft_reset        per-port soft reset requests
//   parity_done       parity byte has been written
//   low_packet_valid  pkt_valid fell while the FIFO was full
//   write_enb_reg     register-block write enable
//   detect_add .. drop_state  one-hot state decodes
//   busy              source stall
//   port_sel          latched destination port
//   wait_timeout      one-cycle pulse in the first DROP_PACKET cycle after
//                     a wait timeout
// ---------------------------------------------------------------------------
module router_fsm_np #(
   parameter int NUM_PORTS    = 3,
   parameter int ADDR_W       = 2,
   parameter int WAIT_TIMEOUT = 64
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic                 fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   input  logic                 parity_done,
   input  logic                 low_packet_valid,
   output logic                 write_enb_reg,
   output logic                 detect_add,
   output logic                 ld_state,
   output logic                 laf_state,
   output logic                 lfd_state,
   output logic                 full_state,
   output logic                 rst_int_reg,
   output logic                 drop_state,
   output logic                 busy,
   output logic [ADDR_W-1:0]    port_sel,
   output logic                 wait_timeout
);

   localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      LOAD_FIRST_DATA    = 4'd1,
      LOAD_DATA          = 4'd2,
      FIFO_FULL_STATE    = 4'd3,
      LOAD_AFTER_FULL    = 4'd4,
      LOAD_PARITY        = 4'd5,
      CHECK_PARITY_ERROR = 4'd6,
      WAIT_TILL_EMPTY    = 4'd7,
      DROP_PACKET        = 4'd8
   } state_t;

   // Address is valid only below NUM_PORTS.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] idx);
      return (int'(idx) < NUM_PORTS);
   endfunction

   // Bounded per-port bit select: out-of-range indices read as 0 and never
   // touch a bit beyond NUM_PORTS-1.
   function automatic logic sel_bit(input logic [NUM_PORTS-1:0] vec,
                                    input logic [ADDR_W-1:0]    idx);
      logic b;
      b = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (idx == ADDR_W'(i)) begin
            b = vec[i];
         end else begin
            b = b;
         end
      end
      return b;
   endfunction

   state_t            r_state;
   state_t            w_fsm_nxt;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_port_sel;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_wait_timeout;

   logic w_addr_ok;
   logic w_empty_addr;
   logic w_empty_sel;
   logic w_soft_sel;
   logic w_timeout;

   assign w_addr_ok    = addr_ok(data_in);
   assign w_empty_addr = sel_bit(fifo_empty, data_in);
   assign w_empty_sel  = sel_bit(fifo_empty, r_port_sel);
   // sel_bit already returns 0 for an invalid port_sel.
   assign w_soft_sel   = sel_bit(soft_reset, r_port_sel);
   assign w_timeout    = (WAIT_TIMEOUT != 0) &&
                         (r_wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));

   // Soft reset of the selected port overrides the normal transition.
   assign w_state_nxt  = w_soft_sel ? DECODE_ADDRESS : w_fsm_nxt;

   assign port_sel     = r_port_sel;
   assign wait_timeout = r_wait_timeout;

   // State, destination latch, wait counter and timeout pulse registers.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state        <= DECODE_ADDRESS;
         r_port_sel     <= '0;
         r_wait_cnt     <= '0;
         r_wait_timeout <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_port_sel     <= (r_state == DECODE_ADDRESS) ? data_in : r_port_sel;
         r_wait_cnt     <= (r_state == WAIT_TILL_EMPTY) ?
                           (r_wait_cnt + CNT_W'(1)) : '0;
         // Only an actual timeout transition produces the pulse.
         r_wait_timeout <= (r_state == WAIT_TILL_EMPTY) &&
                           (w_state_nxt == DROP_PACKET);
      end
   end

   // Next-state logic before the soft-reset override.
   always_comb begin
      w_fsm_nxt = r_state;
      case (r_state)
         DECODE_ADDRESS: begin
            if (pkt_valid && w_addr_ok && w_empty_addr) w_fsm_nxt = LOAD_FIRST_DATA;
            else if (pkt_valid && w_addr_ok)            w_fsm_nxt = WAIT_TILL_EMPTY;
            else if (pkt_valid)                         w_fsm_nxt = DROP_PACKET;
            else                                        w_fsm_nxt = DECODE_ADDRESS;
         end
         LOAD_FIRST_DATA: w_fsm_nxt = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)       w_fsm_nxt = FIFO_FULL_STATE;
            else if (!pkt_valid) w_fsm_nxt = LOAD_PARITY;
            else                 w_fsm_nxt = LOAD_DATA;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full) w_fsm_nxt = LOAD_AFTER_FULL;
            else            w_fsm_nxt = FIFO_FULL_STATE;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)           w_fsm_nxt = DECODE_ADDRESS;
            else if (low_packet_valid) w_fsm_nxt = LOAD_PARITY;
            else                       w_fsm_nxt = LOAD_DATA;
         end
         LOAD_PARITY: w_fsm_nxt = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            if (fifo_full) w_fsm_nxt = FIFO_FULL_STATE;
            else           w_fsm_nxt = DECODE_ADDRESS;
         end
         WAIT_TILL_EMPTY: begin
            // A FIFO that empties in the timeout cycle still wins.
            if (w_empty_sel)    w_fsm_nxt = LOAD_FIRST_DATA;
            else if (w_timeout) w_fsm_nxt = DROP_PACKET;
            else                w_fsm_nxt = WAIT_TILL_EMPTY;
         end
         DROP_PACKET: begin
            if (pkt_valid) w_fsm_nxt = DROP_PACKET;
            else           w_fsm_nxt = DECODE_ADDRESS;
         end
         default: w_fsm_nxt = DECODE_ADDRESS;
      endcase
   end

   // State decodes, write enable and source stall.
   always_comb begin
      write_enb_reg = 1'b0;
      detect_add    = 1'b0;
      ld_state      = 1'b0;
      laf_state     = 1'b0;
      lfd_state     = 1'b0;
      full_state    = 1'b0;
      rst_int_reg   = 1'b0;
      drop_state    = 1'b0;
      busy          = 1'b0;
      case (r_state)
         DECODE_ADDRESS:     detect_add = 1'b1;
         LOAD_FIRST_DATA: begin
            lfd_state = 1'b1;
            busy      = 1'b1;
         end
         LOAD_DATA: begin
            ld_state      = 1'b1;
            write_enb_reg = 1'b1;
         end
         FIFO_FULL_STATE: begin
            full_state = 1'b1;
            busy       = 1'b1;
         end
         LOAD_AFTER_FULL: begin
            laf_state     = 1'b1;
            write_enb_reg = 1'b1;
            busy          = 1'b1;
         end
         LOAD_PARITY: begin
            write_enb_reg = 1'b1;
            busy          = 1'b1;
         end
         CHECK_PARITY_ERROR: begin
            rst_int_reg = 1'b1;
            busy        = 1'b1;
         end
         WAIT_TILL_EMPTY:    busy = 1'b1;
         DROP_PACKET:        drop_state = 1'b1;
         default:            detect_add = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_router_fsm_np.sv
// ---------------------------------------------------------------------------
// tb_router_fsm_np
// Directed self-checking bench for router_fsm_np (NUM_PORTS=3, ADDR_W=2,
// WAIT_TIMEOUT=4). Inputs change 1 time unit after a rising edge; outputs
// are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_router_fsm_np;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] soft_reset;
   logic       parity_done;
   logic       low_packet_valid;
   logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
   logic       full_state, rst_int_reg, drop_state, busy;
   logic [1:0] port_sel;
   logic       wait_timeout;

   int n_checks = 0;
   int n_errors = 0;

   // {write_enb_reg, detect_add, ld, laf, lfd, full, rst_int, drop, busy}
   localparam logic [8:0] E_DA   = 9'b0_1_0_0_0_0_0_0_0;
   localparam logic [8:0] E_LFD  = 9'b0_0_0_0_1_0_0_0_1;
   localparam logic [8:0] E_LD   = 9'b1_0_1_0_0_0_0_0_0;
   localparam logic [8:0] E_FULL = 9'b0_0_0_0_0_1_0_0_1;
   localparam logic [8:0] E_LAF  = 9'b1_0_0_1_0_0_0_0_1;
   localparam logic [8:0] E_LP   = 9'b1_0_0_0_0_0_0_0_1;
   localparam logic [8:0] E_CPE  = 9'b0_0_0_0_0_0_1_0_1;
   localparam logic [8:0] E_WAIT = 9'b0_0_0_0_0_0_0_0_1;
   localparam logic [8:0] E_DROP = 9'b0_0_0_0_0_0_0_1_0;

   logic [8:0] obs_s;
   assign obs_s = {write_enb_reg, detect_add, ld_state, laf_state, lfd_state,
                   full_state, rst_int_reg, drop_state, busy};

   router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
      .data_in(data_in), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .soft_reset(soft_reset), .parity_done(parity_done),
      .low_packet_valid(low_packet_valid), .write_enb_reg(write_enb_reg),
      .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
      .lfd_state(lfd_state), .full_state(full_state),
      .rst_int_reg(rst_int_reg), .drop_state(drop_state), .busy(busy),
      .port_sel(port_sel), .wait_timeout(wait_timeout));

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [8:0] exp);
      check_val(tag, {23'd0, obs_s}, {23'd0, exp});
   endtask

   initial begin
      resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
      fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0;
      low_packet_valid = 1'b0;
      tick(); tick();
      chk_state("reset_outs", E_DA);
      check_val("reset_port_sel", {30'd0, port_sel}, 32'd0);
      check_val("reset_wto", {31'd0, wait_timeout}, 32'd0);
      resetn = 1'b1;

      // Normal packet to empty port 1
      pkt_valid = 1'b1; data_in = 2'd1;
      tick(); chk_state("p1_lfd", E_LFD);
      check_val("p1_port_sel", {30'd0, port_sel}, 32'd1);
      tick(); chk_state("p1_ld", E_LD);
      tick(); chk_state("p1_ld_hold", E_LD);
      pkt_valid = 1'b0;
      tick(); chk_state("p1_lp", E_LP);
      tick(); chk_state("p1_cpe", E_CPE);
      tick(); chk_state("p1_da", E_DA);
      check_val("p1_port_sel_end", {30'd0, port_sel}, 32'd1);

      // Invalid address 3 held for 5 cycles
      pkt_valid = 1'b1; data_in = 2'd3;
      for (int i = 0; i < 5; i++) begin
         tick(); chk_state($sformatf("drop_%0d", i), E_DROP);
      end
      check_val("drop_port_sel", {30'd0, port_sel}, 32'd3);
      pkt_valid = 1'b0;
      tick(); chk_state("drop_exit", E_DA);

      // Wait timeout on port 2
      fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
      for (int i = 0; i < 4; i++) begin
         tick(); chk_state($sformatf("wait_%0d", i), E_WAIT);
         check_val($sformatf("wait_wto_%0d", i), {31'd0, wait_timeout}, 32'd0);
      end
      tick(); chk_state("to_drop", E_DROP);
      check_val("to_pulse", {31'd0, wait_timeout}, 32'd1);
      tick(); chk_state("to_drop2", E_DROP);
      check_val("to_pulse_end", {31'd0, wait_timeout}, 32'd0);
      pkt_valid = 1'b0;
      tick(); chk_state("to_exit", E_DA);

      // Port 2 empties in the timeout cycle: empty wins
      pkt_valid = 1'b1; data_in = 2'd2;
      for (int i = 0; i < 4; i++) begin
         tick(); chk_state($sformatf("race_wait_%0d", i), E_WAIT);
      end
      fifo_empty = 3'b111;
      tick(); chk_state("race_lfd", E_LFD);
      check_val("race_wto", {31'd0, wait_timeout}, 32'd0);
      tick(); chk_state("race_ld", E_LD);
      check_val("race_wto2", {31'd0, wait_timeout}, 32'd0);
      pkt_valid = 1'b0;
      tick(); chk_state("race_lp", E_LP);
      tick(); chk_state("race_cpe", E_CPE);
      tick(); chk_state("race_da", E_DA);

      // Full handling and soft reset on port 0
      pkt_valid = 1'b1; data_in = 2'd0;
      tick(); chk_state("sr_lfd", E_LFD);
      tick(); chk_state("sr_ld", E_LD);
      fifo_full = 1'b1;
      tick(); chk_state("sr_full", E_FULL);
      tick(); chk_state("sr_full_hold", E_FULL);
      fifo_full = 1'b0;
      tick(); chk_state("sr_laf", E_LAF);
      tick(); chk_state("sr_laf_ld", E_LD);
      soft_reset = 3'b010;
      tick(); chk_state("sr_other_ignored", E_LD);
      soft_reset = 3'b001;
      tick(); chk_state("sr_own", E_DA);
      soft_reset = 3'b000; pkt_valid = 1'b0;
      tick(); chk_state("sr_idle", E_DA);

      // LOAD_AFTER_FULL exits via low_packet_valid and parity_done
      pkt_valid = 1'b1; data_in = 2'd0;
      tick(); tick(); fifo_full = 1'b1;
      tick(); chk_state("laf2_full", E_FULL);
      fifo_full = 1'b0;
      tick(); chk_state("laf2_laf", E_LAF);
      low_packet_valid = 1'b1; pkt_valid = 1'b0;
      tick(); chk_state("laf2_lp", E_LP);
      low_packet_valid = 1'b0;
      tick(); chk_state("laf2_cpe", E_CPE);
      fifo_full = 1'b1;
      tick(); chk_state("cpe_full", E_FULL);
      fifo_full = 1'b0;
      tick(); chk_state("laf3_laf", E_LAF);
      parity_done = 1'b1;
      tick(); chk_state("laf3_done", E_DA);
      parity_done = 1'b0;

      // Reset while in FIFO_FULL_STATE
      pkt_valid = 1'b1; data_in = 2'd1;
      tick(); tick(); fifo_full = 1'b1;
      tick(); chk_state("rst_full", E_FULL);
      resetn = 1'b0; soft_reset = 3'b000;
      tick(); chk_state("rst_da", E_DA);
      check_val("rst_port_sel", {30'd0, port_sel}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      resetn = 1'b1; fifo_full = 1'b0; pkt_valid = 1'b0;
      tick(); chk_state("rst_idle", E_DA);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
